store_checker: RTL and testbench

- Hardware responder on the CPU data-store interface (memwrite, dataadr, writedata). It is the synthesizable counterpart of the simulation pass/fail check, so board runs report the result on LEDs.
- Captures every committed store at posedge clk. Classifies each store as pass, scratch or illegal, runs a no-progress watchdog, and latches a sticky verdict.
- Keeps a circular log of the most recent stores for debug readback.

---
 rtl/store_checker.sv | 149 ++++++++++++++
 tb/tb_store_checker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_checker.sv
// store_checker: classifies committed CPU stores into a sticky pass/fail verdict,
// runs a no-progress watchdog and keeps a circular log of recent stores.
module store_checker #(
  parameter logic [31:0] PASS_ADDR    = 32'd84,
  parameter logic [31:0] PASS_DATA    = 32'd7,
  parameter logic [31:0] SCRATCH_ADDR = 32'd80,
  parameter int          LOG_DEPTH    = 8,
  parameter int          TIMEOUT_CYC  = 1024,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memwrite,
  input  logic [31:0]      dataadr,
  input  logic [31:0]      writedata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] store_count,
  output logic [31:0]      fail_addr,
  output logic [31:0]      fail_data,
  input  logic             log_rd,
  output logic [31:0]      log_addr,
  output logic [31:0]      log_data,
  output logic             log_empty,
  output logic             log_ovf
);

  localparam int AW = $clog2(LOG_DEPTH);
  localparam int WW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(LOG_DEPTH);

  typedef enum logic [1:0] {
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_e;

  state_e           state_q;
  logic             done_q, pass_q, fail_q, tmo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      fa_q, fd_q;
  logic [WW-1:0]    wd_q;

  logic is_pa, is_pd, is_scr;
  logic hit_pass, hit_badpass, hit_scr;
  logic push, pop, full;

  assign is_pa       = (dataadr == PASS_ADDR);
  assign is_pd       = (writedata == PASS_DATA);
  assign is_scr      = (dataadr == SCRATCH_ADDR);
  assign hit_pass    = is_pa && is_pd;
  assign hit_badpass = is_pa && !is_pd;
  assign hit_scr     = !is_pa && is_scr;

  assign push = memwrite && (state_q == S_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      fa_q    <= '0;
      fd_q    <= '0;
      wd_q    <= '0;
    end else if (state_q == S_RUN) begin
      if (memwrite) begin
        wd_q <= '0;
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        unique case (1'b1)
          hit_pass: begin
            state_q <= S_PASS;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end
          hit_scr: begin
          end
          hit_badpass: begin
            state_q <= S_FAIL;
            done_q  <= 1'b1;
            fail_q  <= 1'b1;
            fa_q    <= dataadr;
            fd_q    <= writedata;
          end
          default: begin
            state_q <= S_FAIL;
            done_q  <= 1'b1;
            fail_q  <= 1'b1;
            fa_q    <= dataadr;
            fd_q    <= writedata;
          end
        endcase
      end else if (wd_q == WD_LAST) begin
        state_q <= S_TIMEOUT;
        done_q  <= 1'b1;
        fail_q  <= 1'b1;
        tmo_q   <= 1'b1;
      end else begin
        wd_q <= wd_q + 1'b1;
      end
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = tmo_q;
  assign store_count = cnt_q;
  assign fail_addr   = fa_q;
  assign fail_data   = fd_q;

  logic [63:0] mem_q [LOG_DEPTH];
  logic [AW:0] wptr_q, rptr_q, occ_q;
  logic        ovf_q;

  assign full = (occ_q == DEPTH_C);
  assign pop  = log_rd && (occ_q != '0);

  // A push into a full log drops the oldest entry, so the read side advances too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LOG_DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wptr_q[AW-1:0]] <= {dataadr, writedata};
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop || (push && full)) rptr_q <= rptr_q + 1'b1;
      if (push && full) ovf_q <= 1'b1;
      if (push && !full && !pop) occ_q <= occ_q + 1'b1;
      else if (pop && !push) occ_q <= occ_q - 1'b1;
    end
  end

  assign {log_addr, log_data} = mem_q[rptr_q[AW-1:0]];
  assign log_empty = (occ_q == '0);
  assign log_ovf   = ovf_q;

endmodule

// File: tb/tb_store_checker.sv
// Bench for store_checker: vector table, directed corner sequences and
// randomized stores compared against a queue-based reference model.
module tb_store_checker;

  localparam int TO    = 16;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        memwrite;
  logic [31:0] dataadr, writedata;
  logic        log_rd;
  logic        done, pass, fail, timeout;
  logic [15:0] store_count;
  logic [31:0] fail_addr, fail_data, log_addr, log_data;
  logic        log_empty, log_ovf;

  always #5 clk = ~clk;

  store_checker #(.TIMEOUT_CYC(TO), .LOG_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .store_count(store_count), .fail_addr(fail_addr),
    .fail_data(fail_data), .log_rd(log_rd), .log_addr(log_addr),
    .log_data(log_data), .log_empty(log_empty), .log_ovf(log_ovf)
  );

  int nvec = 0;
  int nmis = 0;

  typedef enum {M_RUN, M_PASS, M_FAIL, M_TO} verdict_e;
  verdict_e    m_v;
  int          m_idle, m_cnt;
  logic [31:0] m_fa, m_fd;
  logic [63:0] m_log[$];
  bit          m_ovf, m_fresh;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_v = M_RUN; m_idle = 0; m_cnt = 0;
    m_fa = '0; m_fd = '0; m_log.delete();
    m_ovf = 0; m_fresh = 1;
  endtask

  task automatic model_step(input logic mw, input logic [31:0] a, d,
                            input logic rd);
    bit push, was_full;
    push = mw && (m_v == M_RUN);
    was_full = (m_log.size() == DEPTH);
    if (rd && m_log.size() > 0) void'(m_log.pop_front());
    if (push) begin
      m_log.push_back({a, d});
      if (was_full) m_ovf = 1;
      if (m_log.size() > DEPTH) void'(m_log.pop_front());
      m_fresh = 0;
      if (m_cnt < 65535) m_cnt++;
      m_idle = 0;
      if (a == 32'd84) m_v = (d == 32'd7) ? M_PASS : M_FAIL;
      else if (a != 32'd80) m_v = M_FAIL;
      if (m_v == M_FAIL) begin m_fa = a; m_fd = d; end
    end else if (m_v == M_RUN) begin
      if (m_idle == TO - 1) m_v = M_TO;
      else m_idle++;
    end
  endtask

  task automatic check_all();
    chk("done", done, m_v != M_RUN);
    chk("pass", pass, m_v == M_PASS);
    chk("fail", fail, m_v == M_FAIL || m_v == M_TO);
    chk("timeout", timeout, m_v == M_TO);
    chk("store_count", store_count, m_cnt);
    chk("fail_addr", fail_addr, m_fa);
    chk("fail_data", fail_data, m_fd);
    chk("log_empty", log_empty, m_log.size() == 0);
    chk("log_ovf", log_ovf, m_ovf);
    if (m_log.size() > 0) begin
      chk("log_addr", log_addr, m_log[0][63:32]);
      chk("log_data", log_data, m_log[0][31:0]);
    end else if (m_fresh) begin
      chk("log_addr_rst", log_addr, 32'd0);
      chk("log_data_rst", log_data, 32'd0);
    end
  endtask

  task automatic cycle(input logic mw, input logic [31:0] a, d,
                       input logic rd);
    memwrite = mw; dataadr = a; writedata = d; log_rd = rd;
    @(posedge clk);
    model_step(mw, a, d, rd);
    #1;
    check_all();
  endtask

  task automatic do_reset(input int n);
    memwrite = 0; dataadr = '0; writedata = '0; log_rd = 0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pulse_rst();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_async_fail", fail, 1'b0);
    chk("rst_async_empty", log_empty, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        mw;
    logic [31:0] a, d;
    logic        rd;
    logic        e_done, e_pass;
    logic [15:0] e_cnt;
    logic        e_empty;
    logic [31:0] e_ldata;
  } vec_t;

  vec_t tbl[7];

  initial begin
    rst = 1'b1;
    tbl[0] = '{1'b1, 32'd80, 32'd5,  1'b0, 1'b0, 1'b0, 16'd1, 1'b0, 32'd5};
    tbl[1] = '{1'b1, 32'd80, 32'd12, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 32'd5};
    tbl[2] = '{1'b1, 32'd84, 32'd7,  1'b0, 1'b1, 1'b1, 16'd3, 1'b0, 32'd5};
    tbl[3] = '{1'b0, 32'd0,  32'd0,  1'b1, 1'b1, 1'b1, 16'd3, 1'b0, 32'd12};
    tbl[4] = '{1'b0, 32'd0,  32'd0,  1'b1, 1'b1, 1'b1, 16'd3, 1'b0, 32'd7};
    tbl[5] = '{1'b0, 32'd0,  32'd0,  1'b1, 1'b1, 1'b1, 16'd3, 1'b1, 32'd0};
    tbl[6] = '{1'b1, 32'd84, 32'd6,  1'b0, 1'b1, 1'b1, 16'd3, 1'b1, 32'd0};

    do_reset(10);
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].mw, tbl[i].a, tbl[i].d, tbl[i].rd);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("tbl%0d_pass", i), pass, tbl[i].e_pass);
      chk($sformatf("tbl%0d_fail", i), fail, 1'b0);
      chk($sformatf("tbl%0d_cnt", i), store_count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_empty", i), log_empty, tbl[i].e_empty);
      if (!tbl[i].e_empty)
        chk($sformatf("tbl%0d_ldata", i), log_data, tbl[i].e_ldata);
    end

    do_reset(2);
    cycle(1, 32'd84, 32'd6, 0);
    chk("bad_pass_fail", fail, 1'b1);
    chk("bad_pass_pass", pass, 1'b0);
    chk("bad_pass_faddr", fail_addr, 32'd84);
    chk("bad_pass_fdata", fail_data, 32'd6);
    cycle(1, 32'd84, 32'd7, 0);
    chk("ignored_cnt", store_count, 16'd1);
    chk("ignored_pass", pass, 1'b0);

    do_reset(2);
    cycle(1, 32'd88, 32'd7, 0);
    chk("illegal_fail", fail, 1'b1);
    chk("illegal_faddr", fail_addr, 32'd88);
    pulse_rst();
    cycle(0, 0, 0, 0);

    do_reset(2);
    for (int i = 0; i < TO - 1; i++) cycle(0, 0, 0, 0);
    chk("wd_pre_timeout", timeout, 1'b0);
    cycle(0, 0, 0, 0);
    chk("wd_timeout", timeout, 1'b1);
    chk("wd_fail", fail, 1'b1);
    chk("wd_done", done, 1'b1);

    do_reset(2);
    for (int i = 0; i < TO - 1; i++) cycle(0, 0, 0, 0);
    cycle(1, 32'd80, 32'd1, 0);
    chk("wd_save_done", done, 1'b0);
    for (int i = 0; i < TO - 1; i++) cycle(0, 0, 0, 0);
    chk("wd_restart_done", done, 1'b0);
    cycle(0, 0, 0, 0);
    chk("wd_restart_tmo", timeout, 1'b1);

    do_reset(2);
    for (int i = 1; i <= 10; i++) cycle(1, 32'd80, i, 0);
    chk("ovf_set", log_ovf, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("ovf_pop%0d", i), log_data, 3 + i);
      cycle(0, 0, 0, 1);
    end
    chk("ovf_drained", log_empty, 1'b1);

    do_reset(2);
    for (int i = 1; i <= DEPTH; i++) cycle(1, 32'd80, i, 0);
    chk("full_ovf_clear", log_ovf, 1'b0);
    chk("full_head", log_data, 32'd1);
    cycle(1, 32'd80, 32'd100, 1);
    chk("pp_ovf", log_ovf, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("pp_pop%0d", i), log_data,
          (i == DEPTH - 1) ? 32'd100 : 32'(i + 2));
      chk($sformatf("pp_nempty%0d", i), log_empty, 1'b0);
      cycle(0, 0, 0, 1);
    end
    chk("pp_drained", log_empty, 1'b1);

    for (int run = 0; run < 30; run++) begin
      int pmw;
      pmw = (run % 3 == 0) ? 10 : 60;
      do_reset(2);
      for (int c = 0; c < 50; c++) begin
        logic        mw, rd;
        logic [31:0] a, d;
        int          r;
        mw = ($urandom_range(0, 99) < pmw);
        rd = ($urandom_range(0, 99) < 30);
        r  = $urandom_range(0, 99);
        d  = $urandom;
        if (r < 85) a = 32'd80;
        else if (r < 90) begin a = 32'd84; d = 32'd7; end
        else if (r < 95) begin a = 32'd84; d = $urandom_range(0, 15); end
        else a = $urandom;
        cycle(mw, a, d, rd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
